// File: rtl/dm_pkg.sv
// Shared encodings for the MEM-stage data memory: access sizes, FSM states,
// lane count and the alignment rule.
package dm_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam int BE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        return ((size == SZ_HALF) && lo[0]) || ((size == SZ_WORD) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Byte-lane steering: builds store byte enables and the merged write word, and
// extracts the sign- or zero-extended load value from the addressed word.
module dm_lane_align
    import dm_pkg::*;
(
    input  logic [1:0]      size,
    input  logic [1:0]      addr_lo,
    input  logic            is_unsigned,
    input  logic [31:0]     wdata,
    input  logic [31:0]     old_word,
    output logic [BE_W-1:0] be,
    output logic [31:0]     merged,
    output logic [31:0]     load_data
);

    logic [31:0] wide;
    logic [31:0] shifted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        be   = '0;
        wide = wdata;
        case (size)
            SZ_BYTE: begin
                be   = 4'b0001 << addr_lo;
                wide = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                be   = 4'b0011 << addr_lo;
                wide = {2{wdata[15:0]}};
            end
            SZ_WORD: be = 4'b1111;
            default: be = '0;
        endcase
        merged = old_word;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) merged[8*i +: 8] = wide[8*i +: 8];
        end
    end

    // Shifting by the byte offset puts the addressed byte in lane 0.
    assign shifted = old_word >> {addr_lo, 3'b000};
    assign byte_v  = shifted[7:0];
    assign half_v  = addr_lo[1] ? old_word[31:16] : old_word[15:0];

    always_comb begin
        load_data = '0;
        case (size)
            SZ_BYTE: load_data = is_unsigned ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
            SZ_HALF: load_data = is_unsigned ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
            SZ_WORD: load_data = old_word;
            default: load_data = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage data memory with byte/half/word access, error checking and a fixed
// access latency. Define DM_TRACE_EN to print every committed store.
module data_mem_ctrl
    import dm_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        stall,
    output logic [1:0]  dbg_state
);

    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam int          CW   = 4;
    localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);

    // Handshake: a request transfers on a rising edge where req_valid and
    // req_ready are both high; req_ready is high only in IDLE and inputs are
    // ignored otherwise. rsp_valid is a single-cycle pulse in RESP.

    state_t         state;
    logic [CW-1:0]  cnt;
    logic           lat_we;
    logic           lat_uns;
    logic [1:0]     lat_size;
    logic [31:0]    lat_addr;
    logic [31:0]    lat_wdata;
    logic [31:0]    mem [DEPTH_WORDS];

    logic           in_idle;
    logic           accept;
    logic           commit;
    logic           cur_we;
    logic           cur_uns;
    logic [1:0]     cur_size;
    logic [31:0]    cur_addr;
    logic [31:0]    cur_wdata;
    logic [31:0]    offset;
    logic [AW-1:0]  idx;
    logic           err;
    logic [31:0]    rd_word;
    logic [31:0]    merged;
    logic [31:0]    load_data;
    logic [BE_W-1:0] lane_be;

    assign in_idle = (state == ST_IDLE);
    assign accept  = in_idle & req_valid;
    // With LATENCY=1 the accepting edge is also the commit edge, so the live
    // request is used there instead of the latched copy.
    assign commit  = (LATENCY == 1) ? accept : ((state == ST_BUSY) && (cnt == CW'(1)));

    assign cur_we    = in_idle ? req_we       : lat_we;
    assign cur_uns   = in_idle ? req_unsigned : lat_uns;
    assign cur_size  = in_idle ? req_size     : lat_size;
    assign cur_addr  = in_idle ? req_addr     : lat_addr;
    assign cur_wdata = in_idle ? req_wdata    : lat_wdata;

    // Addresses below BASE_ADDR wrap to large offsets and fail the range test.
    assign offset  = cur_addr - BASE_ADDR;
    assign idx     = offset[AW+1:2];
    assign err     = (cur_size == 2'd3) || misaligned(cur_size, cur_addr[1:0]) || (offset >= SPAN);
    assign rd_word = mem[idx];

    assign stall     = req_valid & ~req_ready;
    assign dbg_state = state;

    dm_lane_align u_align (
        .size        (cur_size),
        .addr_lo     (cur_addr[1:0]),
        .is_unsigned (cur_uns),
        .wdata       (cur_wdata),
        .old_word    (rd_word),
        .be          (lane_be),
        .merged      (merged),
        .load_data   (load_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_uns   <= 1'b0;
            lat_size  <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        lat_we    <= req_we;
                        lat_uns   <= req_unsigned;
                        lat_size  <= req_size;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        req_ready <= 1'b0;
                        if (LATENCY == 1) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                        end else begin
                            cnt   <= CW'(LATENCY - 1);
                            state <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                    end
                end
                ST_RESP: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
            if (commit) begin
                rsp_err   <= err;
                rsp_rdata <= (err || cur_we) ? 32'h0 : load_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
        end else if (commit && cur_we && !err && (|lane_be)) begin
            mem[idx] <= merged;
        end
    end

`ifdef DM_TRACE_EN
    logic [31:0] lat_pc;
    logic [31:0] cur_pc;

    assign cur_pc = in_idle ? req_pc : lat_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            lat_pc <= '0;
        end else begin
            if (accept) lat_pc <= req_pc;
            if (commit && cur_we && !err)
                $display("%d@%h: *%h <= %h", $time, cur_pc, {cur_addr[31:2], 2'b00}, merged);
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^req_pc;
`endif

endmodule
